// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory completer.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2
    } err_e;

    // Number of byte-offset bits below the word index.
    function automatic int unsigned lane_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W register memory: byte-strobed synchronous write,
// asynchronous read, synchronous clear.
module apb_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer fronting a word-addressed register memory with wait
// states, byte strobes and alignment/range error responses.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = lane_lsb(DATA_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WCNT_W = 4;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_L     = WCNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;

    logic [ADDR_W-1:0]   word_idx;
    err_e                err;
    logic                done;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // Error decode works only on the request captured in the setup phase.
    assign word_idx = addr_q >> LSB;

    always_comb begin
        err = ERR_NONE;
        if ((addr_q & ALIGN_MASK) != '0) begin
            err = ERR_ALIGN;
        end else if ({1'b0, word_idx} >= DEPTH_L) begin
            err = ERR_RANGE;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        case (state_q)
            IDLE: begin
                // An access phase without a setup phase is ignored.
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    wcnt_d  = WAIT_L;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WCNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done    = (state_q == ACCESS) && psel && penable && (wcnt_q == '0);
        pready  = done;
        pslverr = done && (err != ERR_NONE);
        mem_we  = done && write_q && (err == ERR_NONE);
        prdata  = '0;
        if (done && !write_q && (err == ERR_NONE)) begin
            prdata = mem_rdata;
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (pclk),
        .rst   (prst),
        .we    (mem_we),
        .idx   (IDX_W'(word_idx)),
        .wdata (wdata_q),
        .strb  (strb_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized self-checking bench for apb_mem_slave: a WAIT_CYCLES=2 instance
// and a zero-wait instance, both checked against a word-array model.
module tb_apb_mem_slave;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned DEP = 16;
    localparam int unsigned WS  = 2;

    logic          clk = 1'b0;
    logic          prst;
    logic          psel_a, penable_a, psel_b, penable_b;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata_a, prdata_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [31:0]   model_a [DEP];
    logic [31:0]   model_b [DEP];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(WS)) dut (
        .pclk(clk), .prst(prst), .psel(psel_a), .penable(penable_a), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(0)) dut0 (
        .pclk(clk), .prst(prst), .psel(psel_b), .penable(penable_b), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psel_a = 1'b0; penable_a = 1'b0;
            psel_b = 1'b0; penable_b = 1'b0;
        end
    endtask

    // One complete transfer; checks latency, pslverr and read data against the model.
    task automatic xfer(input bit sel_b, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int done_cyc);
        int          lat;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat = -1;
        rd  = '0;
        err = 1'b0;
        done_cyc = 0;
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
        if (sel_b) begin psel_b = 1'b1; penable_b = 1'b0; end
        else       begin psel_a = 1'b1; penable_a = 1'b0; end
        #1 chk("setup_pready", sel_b ? pready_b : pready_a, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sel_b) penable_b = 1'b1; else penable_a = 1'b1;
            // The completer must work from the captured request, not the live bus.
            paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = 1'($urandom);
            #1;
            if (sel_b ? pready_b : pready_a) begin
                lat = n;
                rd  = sel_b ? prdata_b : prdata_a;
                err = sel_b ? pslverr_b : pslverr_a;
                done_cyc = cyc;
                break;
            end
        end
        if (lat < 0) chk("pready_timeout", 1'b0, 1'b1);
        chk(sel_b ? "latency_b" : "latency_a", 64'(lat), sel_b ? 64'd1 : 64'(1 + WS));
        idx     = int'(addr) / 4;
        exp_err = (addr % 4 != 0) || (idx >= int'(DEP));
        chk("pslverr", err, exp_err);
        if (!wr) begin
            exp_rd = exp_err ? 32'h0 : (sel_b ? model_b[idx] : model_a[idx]);
            chk("prdata", rd, exp_rd);
        end else if (!exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    if (sel_b) model_b[idx][8*b +: 8] = data[8*b +: 8];
                    else       model_a[idx][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pready"},  {pready_a, pready_b},   2'b00);
        chk({tag, "_pslverr"}, {pslverr_a, pslverr_b}, 2'b00);
        chk({tag, "_prdata"},  {prdata_a, prdata_b},   64'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          c1, c2;

        prst = 1'b1;
        psel_a = 1'b0; penable_a = 1'b0; psel_b = 1'b0; penable_b = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        for (int i = 0; i < int'(DEP); i++) begin model_a[i] = '0; model_b[i] = '0; end
        repeat (3) @(negedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk);
        prst = 1'b0;

        // Full write then read back.
        xfer(0, 1, 8'h08, 32'hDEADBEEF, 4'hF, rd, err, c1);
        xfer(0, 0, 8'h08, 32'h0, 4'h0, rd, err, c1);
        chk("rd_08", rd, 32'hDEADBEEF);
        chk("rd_08_err", err, 1'b0);
        bus_idle(1);

        // Partial strobes over existing contents.
        xfer(0, 1, 8'h0C, 32'hAABBCCDD, 4'hF, rd, err, c1);
        xfer(0, 1, 8'h0C, 32'h11223344, 4'h5, rd, err, c1);
        xfer(0, 0, 8'h0C, 32'h0, 4'h0, rd, err, c1);
        chk("rd_0c_strb", rd, 32'hAA22CC44);
        bus_idle(1);

        // Out-of-range and misaligned writes must error and leave memory alone.
        xfer(0, 1, 8'h04, 32'h01020304, 4'hF, rd, err, c1);
        xfer(0, 1, 8'h40, 32'hFFFFFFFF, 4'hF, rd, err, c1);
        chk("range_err", err, 1'b1);
        xfer(0, 1, 8'h05, 32'hFFFFFFFF, 4'hF, rd, err, c1);
        chk("align_err", err, 1'b1);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, err, c1);
        chk("rd_04_kept", rd, 32'h01020304);
        bus_idle(1);

        // Abort during a wait cycle.
        xfer(0, 1, 8'h10, 32'hCAFEF00D, 4'hF, rd, err, c1);
        bus_idle(1);
        @(negedge clk);
        paddr = 8'h10; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel_a = 1'b1; penable_a = 1'b0;
        @(negedge clk);
        penable_a = 1'b1;
        #1 chk("abort_wait_pready", pready_a, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            psel_a = 1'b0; penable_a = 1'b0;
            #1 chk("abort_pready", pready_a, 1'b0);
        end
        xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, err, c1);
        chk("rd_10_after_abort", rd, 32'hCAFEF00D);
        bus_idle(1);

        // Zero-wait instance: back-to-back reads complete every 2 cycles.
        xfer(1, 1, 8'h20, 32'h5A5AA5A5, 4'hF, rd, err, c1);
        xfer(1, 0, 8'h20, 32'h0, 4'h0, rd, err, c1);
        xfer(1, 0, 8'h08, 32'h0, 4'h0, rd, err, c2);
        chk("b2b_period", 64'(c2 - c1), 64'd2);
        bus_idle(1);

        // Randomized traffic on both instances, mixing gaps and back-to-back.
        for (int t = 0; t < 120; t++) begin
            bit          sel_b;
            bit          wr;
            logic [7:0]  addr;
            int          gap;
            sel_b = (t % 3 == 2);
            wr    = 1'($urandom);
            addr  = 8'($urandom_range(0, 19) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr | 8'($urandom_range(1, 3));
            xfer(sel_b, wr, addr, $urandom, 4'($urandom), rd, err, c1);
            gap = $urandom_range(0, 2);
            if (gap != 0 || (t % 3 == 1) || (t % 3 == 2)) bus_idle(gap == 0 ? 1 : gap);
        end

        // Reset during the ACCESS phase of a write.
        @(negedge clk);
        paddr = 8'h14; pwrite = 1'b1; pwdata = 32'h77777777; pstrb = 4'hF;
        psel_a = 1'b1; penable_a = 1'b0;
        @(negedge clk);
        penable_a = 1'b1;
        #1 prst = 1'b1;
        @(negedge clk);
        #1 chk_outputs_zero("midreset");
        prst = 1'b0;
        for (int i = 0; i < int'(DEP); i++) begin model_a[i] = '0; model_b[i] = '0; end
        bus_idle(1);
        for (int i = 0; i < int'(DEP); i++) begin
            xfer(0, 0, 8'(i * 4), 32'h0, 4'h0, rd, err, c1);
            chk("cleared_a", rd, 32'h0);
        end
        xfer(1, 0, 8'h20, 32'h0, 4'h0, rd, err, c1);
        chk("cleared_b", rd, 32'h0);
        bus_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
